fp_add_align: RTL and testbench

FP_ADD_ALIGN -- requirements
Module: fp_add_align

---
 rtl/fp_pkg.sv | 25 ++
 rtl/mant_rshift.sv | 17 +
 rtl/fp_add_align.sv | 155 +++++++++++++++
 tb/tb_fp_add_align.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision add/sub datapath.
//   EXP_W/FRAC_W  : IEEE-754 single field widths
//   MANT_W        : {carry, hidden, fraction} working mantissa width
//   EXP_MAX       : all-ones exponent marking Inf/NaN
//   fp32_t        : packed {sign, exponent, fraction} view of a 32-bit word
package fp_pkg;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = 25;
   localparam int BIAS   = 127;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   typedef struct packed {
      logic              s;
      logic [EXP_W-1:0]  e;
      logic [FRAC_W-1:0] f;
   } fp32_t;

   // {carry=0, hidden, frac}; denormals flush to a zero mantissa.
   function automatic logic [MANT_W-1:0] unpack_mant(input fp32_t x);
      logic hid;
      hid = (x.e != '0);
      return {1'b0, hid, (hid ? x.f : {FRAC_W{1'b0}})};
   endfunction
endpackage

// File: rtl/mant_rshift.sv
// Combinational right shifter for the alignment stage.
//   din   : 25-bit mantissa to shift
//   shamt : 8-bit shift amount (exponent difference)
//   dout  : din >> shamt, zero once shamt reaches the mantissa width;
//           shifted-out bits are truncated.
module mant_rshift
   import fp_pkg::*;
(
   input  logic [MANT_W-1:0] din,
   input  logic [EXP_W-1:0]  shamt,
   output logic [MANT_W-1:0] dout
);
   always_comb begin
      dout = '0;
      if (shamt < EXP_W'(MANT_W)) dout = din >> shamt;
   end
endmodule

// File: rtl/fp_add_align.sv
// Two-stage front end of an FP32 adder: S1 unpacks, compares and swaps the
// operands; S2 aligns the small mantissa and adds/subtracts. The result is
// left un-normalized for the downstream normalizer.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake; in_a, in_b, in_sub (A-B when 1)
//   out_valid/out_ready   : result handshake
//   out_s, out_e, out_m   : sign, larger operand's exponent, {carry,hidden,frac}
//   out_zero, out_special : exact zero result / Inf-NaN operand seen
module fp_add_align
   import fp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_a,
   input  logic [31:0]       in_b,
   input  logic              in_sub,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_s,
   output logic [EXP_W-1:0]  out_e,
   output logic [MANT_W-1:0] out_m,
   output logic              out_zero,
   output logic              out_special
);
   fp32_t op_a, op_b;
   logic  b_eff_s, a_is_big, a_spec, b_spec;
   logic  s1_advance, s1_load, s2_load;

   logic s1_valid_q, s1_valid_d;
   logic s1_big_s_q, s1_big_s_d, s1_small_s_q, s1_small_s_d;
   logic [EXP_W-1:0]  s1_big_e_q, s1_big_e_d, s1_diff_q, s1_diff_d;
   logic [MANT_W-1:0] s1_big_m_q, s1_big_m_d, s1_small_m_q, s1_small_m_d;
   logic s1_special_q, s1_special_d, s1_spec_s_q, s1_spec_s_d;
   logic [FRAC_W-1:0] s1_spec_f_q, s1_spec_f_d;

   logic              out_valid_q, out_valid_d, out_s_q, out_s_d;
   logic [EXP_W-1:0]  out_e_q, out_e_d;
   logic [MANT_W-1:0] out_m_q, out_m_d;
   logic              out_zero_q, out_zero_d, out_special_q, out_special_d;

   logic [MANT_W-1:0] small_shifted, mant_sum;

   // The output register is the S2 valid stage, so S1 may advance whenever
   // the output slot is empty or being drained. No term depends on in_valid.
   assign s1_advance = !out_valid_q || out_ready;
   assign in_ready   = !s1_valid_q || s1_advance;
   assign s1_load    = in_valid && in_ready;
   assign s2_load    = s1_advance && s1_valid_q;

   always_comb begin
      op_a     = fp32_t'(in_a);
      op_b     = fp32_t'(in_b);
      b_eff_s  = op_b.s ^ in_sub;
      // Magnitude order on {exp,frac}; ties keep A as the big operand.
      a_is_big = ({op_a.e, op_a.f} >= {op_b.e, op_b.f});
      a_spec   = (op_a.e == EXP_MAX);
      b_spec   = (op_b.e == EXP_MAX);

      s1_valid_d   = in_ready ? in_valid : s1_valid_q;
      s1_big_s_d   = a_is_big ? op_a.s : b_eff_s;
      s1_small_s_d = a_is_big ? b_eff_s : op_a.s;
      s1_big_e_d   = a_is_big ? op_a.e : op_b.e;
      s1_diff_d    = a_is_big ? (op_a.e - op_b.e) : (op_b.e - op_a.e);
      s1_big_m_d   = a_is_big ? unpack_mant(op_a) : unpack_mant(op_b);
      s1_small_m_d = a_is_big ? unpack_mant(op_b) : unpack_mant(op_a);
      s1_special_d = a_spec || b_spec;
      s1_spec_s_d  = a_spec ? op_a.s : b_eff_s;
      s1_spec_f_d  = a_spec ? op_a.f : op_b.f;
   end

   mant_rshift u_rshift (
      .din   (s1_small_m_q),
      .shamt (s1_diff_q),
      .dout  (small_shifted)
   );

   always_comb begin
      // big >= small after the swap, so the subtraction never wraps.
      mant_sum = (s1_big_s_q == s1_small_s_q) ? (s1_big_m_q + small_shifted)
                                               : (s1_big_m_q - small_shifted);

      out_valid_d   = s1_advance ? s1_valid_q : out_valid_q;
      out_s_d       = out_s_q;
      out_e_d       = out_e_q;
      out_m_d       = out_m_q;
      out_zero_d    = out_zero_q;
      out_special_d = out_special_q;

      if (s2_load) begin
         if (s1_special_q) begin
            out_s_d       = s1_spec_s_q;
            out_e_d       = EXP_MAX;
            out_m_d       = {2'b01, s1_spec_f_q};
            out_zero_d    = 1'b0;
            out_special_d = 1'b1;
         end else if (mant_sum == '0) begin
            out_s_d       = 1'b0;
            out_e_d       = '0;
            out_m_d       = '0;
            out_zero_d    = 1'b1;
            out_special_d = 1'b0;
         end else begin
            out_s_d       = s1_big_s_q;
            out_e_d       = s1_big_e_q;
            out_m_d       = mant_sum;
            out_zero_d    = 1'b0;
            out_special_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_s_q       <= 1'b0;
         out_e_q       <= '0;
         out_m_q       <= '0;
         out_zero_q    <= 1'b0;
         out_special_q <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         out_valid_q   <= out_valid_d;
         out_s_q       <= out_s_d;
         out_e_q       <= out_e_d;
         out_m_q       <= out_m_d;
         out_zero_q    <= out_zero_d;
         out_special_q <= out_special_d;
      end
   end

   // S1 payload is qualified by s1_valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (s1_load) begin
         s1_big_s_q   <= s1_big_s_d;
         s1_small_s_q <= s1_small_s_d;
         s1_big_e_q   <= s1_big_e_d;
         s1_diff_q    <= s1_diff_d;
         s1_big_m_q   <= s1_big_m_d;
         s1_small_m_q <= s1_small_m_d;
         s1_special_q <= s1_special_d;
         s1_spec_s_q  <= s1_spec_s_d;
         s1_spec_f_q  <= s1_spec_f_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_s       = out_s_q;
   assign out_e       = out_e_q;
   assign out_m       = out_m_q;
   assign out_zero    = out_zero_q;
   assign out_special = out_special_q;
endmodule

// File: tb/tb_fp_add_align.sv
module tb_fp_add_align;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_sub;
   logic [31:0] in_a, in_b;
   logic        out_valid, out_ready, out_s, out_zero, out_special;
   logic [7:0]  out_e;
   logic [24:0] out_m;

   always #5 clk = ~clk;

   fp_add_align dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
      .out_ready(out_ready), .out_s(out_s), .out_e(out_e), .out_m(out_m),
      .out_zero(out_zero), .out_special(out_special)
   );

   typedef struct packed {
      logic        s;
      logic [7:0]  e;
      logic [24:0] m;
      logic        z;
      logic        sp;
   } res_t;

   res_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic res_t mk(input logic s, input logic [7:0] e,
                               input logic [24:0] m, input logic z, input logic sp);
      res_t r;
      r.s = s; r.e = e; r.m = m; r.z = z; r.sp = sp;
      return r;
   endfunction

   // Reference: align the smaller magnitude with integer arithmetic.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub);
      res_t r;
      int unsigned ea, eb, ma, mb, ebig, esml, mbig, msml, de, sh, sum;
      logic sa, sb, sbig, ssml;
      r  = '0;
      ea = a[30:23];
      eb = b[30:23];
      ma = (ea != 0) ? (32'h0080_0000 | a[22:0]) : 0;
      mb = (eb != 0) ? (32'h0080_0000 | b[22:0]) : 0;
      sa = a[31];
      sb = b[31] ^ sub;
      if (ea == 255 || eb == 255) begin
         r.sp = 1'b1;
         r.e  = 8'hFF;
         r.s  = (ea == 255) ? sa : sb;
         r.m  = 25'(32'h0080_0000 | ((ea == 255) ? a[22:0] : b[22:0]));
         return r;
      end
      if (a[30:0] >= b[30:0]) begin
         ebig = ea; mbig = ma; sbig = sa; esml = eb; msml = mb; ssml = sb;
      end else begin
         ebig = eb; mbig = mb; sbig = sb; esml = ea; msml = ma; ssml = sa;
      end
      de  = ebig - esml;
      sh  = (de >= 25) ? 0 : (msml >> de);
      sum = (sbig == ssml) ? (mbig + sh) : (mbig - sh);
      if (sum == 0) r.z = 1'b1;
      else begin
         r.s = sbig;
         r.e = 8'(ebig);
         r.m = 25'(sum);
      end
      return r;
   endfunction

   task automatic chk_val(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic pin(input logic [31:0] a, input logic [31:0] b, input logic sub, input res_t req);
      chk_val("model_pin", 64'(model(a, b, sub)), 64'(req));
   endtask

   // Present one pair from the falling edge until the DUT takes it.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (in_ready) exp_q.push_back(model(a, b, sub));
      else chk_val("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk); #3; n++;
      end
      chk_val("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Compare process: checks every consumed result and stall stability.
   res_t cur, held;
   logic stalled = 1'b0;
   always @(negedge clk) begin
      #2;
      if (rst) stalled = 1'b0;
      else if (out_valid) begin
         cur = mk(out_s, out_e, out_m, out_zero, out_special);
         if (stalled) chk_val("stall_hold", 64'(cur), 64'(held));
         if (out_ready) begin
            if (exp_q.size() == 0) chk_val("unexpected_out", 64'(cur), 64'd0);
            else chk_val("result", 64'(cur), 64'(exp_q.pop_front()));
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held    = cur;
         end
      end else stalled = 1'b0;
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;

      pin(32'h3F80_0000, 32'h3F80_0000, 1'b0, mk(1'b0, 8'd127, 25'h100_0000, 1'b0, 1'b0));
      pin(32'h4040_0000, 32'hC020_0000, 1'b0, mk(1'b0, 8'd128, 25'h020_0000, 1'b0, 1'b0));
      pin(32'h3F80_0000, 32'h3F80_0000, 1'b1, mk(1'b0, 8'd0,   25'h000_0000, 1'b1, 1'b0));
      pin(32'h3F80_0000, 32'h3080_0000, 1'b0, mk(1'b0, 8'd127, 25'h080_0000, 1'b0, 1'b0));
      pin(32'h7F80_0000, 32'h3F80_0000, 1'b0, mk(1'b0, 8'd255, 25'h080_0000, 1'b0, 1'b1));
      pin(32'h3F80_0000, 32'h4000_0000, 1'b1, mk(1'b1, 8'd128, 25'h040_0000, 1'b0, 1'b0));
      pin(32'h3F80_0000, 32'h7FC0_0001, 1'b0, mk(1'b0, 8'd255, 25'h0C0_0001, 1'b0, 1'b1));

      repeat (3) @(posedge clk);
      #1;
      chk_val("reset_out_valid", 64'(out_valid), 64'd0);
      chk_val("reset_outputs", 64'(mk(out_s, out_e, out_m, out_zero, out_special)), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_val("ready_after_reset", 64'(in_ready), 64'd1);

      // 1.0 + 1.0 with explicit latency check
      send(32'h3F80_0000, 32'h3F80_0000, 1'b0);
      idle();
      #1;
      chk_val("latency_c1", 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      chk_val("latency_c2", 64'(out_valid), 64'd1);
      drain();

      send(32'h4040_0000, 32'hC020_0000, 1'b0);
      send(32'h3F80_0000, 32'h3F80_0000, 1'b1);
      send(32'h3F80_0000, 32'h3080_0000, 1'b0);
      send(32'h7F80_0000, 32'h3F80_0000, 1'b0);
      send(32'h3F80_0000, 32'h4000_0000, 1'b1);
      send(32'h3F80_0000, 32'h7FC0_0001, 1'b0);
      send(32'h0040_0000, 32'h3F80_0000, 1'b0);
      idle();
      drain();

      // Back-to-back pairs into a stalled output
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 32'h4040_0000; in_b = 32'h3F80_0000; in_sub = 1'b0;
      #1;
      chk_val("stall_accept1", 64'(in_ready), 64'd1);
      exp_q.push_back(model(in_a, in_b, in_sub));
      @(negedge clk);
      in_a = 32'h3F80_0000; in_b = 32'h3F00_0000; in_sub = 1'b1;
      #1;
      chk_val("stall_accept2", 64'(in_ready), 64'd1);
      exp_q.push_back(model(in_a, in_b, in_sub));
      @(negedge clk);
      in_a = 32'h4120_0000; in_b = 32'h3F80_0000; in_sub = 1'b0;
      #1;
      chk_val("stall_full", 64'(in_ready), 64'd0);
      @(negedge clk);
      #1;
      chk_val("stall_full2", 64'(in_ready), 64'd0);
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk_val("stall_release", 64'(in_ready), 64'd1);
      exp_q.push_back(model(in_a, in_b, in_sub));
      idle();
      drain();

      // Reset with two pairs in flight
      send(32'h4040_0000, 32'h3F80_0000, 1'b0);
      send(32'h3F80_0000, 32'h4000_0000, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      chk_val("midrst_out_valid", 64'(out_valid), 64'd0);
      chk_val("midrst_outputs", 64'(mk(out_s, out_e, out_m, out_zero, out_special)), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_val("midrst_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         chk_val("no_stale_out", 64'(out_valid), 64'd0);
      end

      // Pipeline still usable after the flush
      send(32'h4120_0000, 32'h3F80_0000, 1'b1);
      idle();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
